// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the PE instruction fetch path: word layout,
// opcode field, opcodes and the sequencer state encoding.
package inst_fetch_pkg;

  localparam int INST_WIDTH = 16;
  localparam int OPC_W      = 3;
  localparam int OPC_MSB    = 2*INST_WIDTH - 1;

  localparam logic [OPC_W-1:0] OP_MUL    = 3'b100;
  localparam logic [OPC_W-1:0] OP_MULADD = 3'b101;
  localparam logic [OPC_W-1:0] OP_MULSUB = 3'b110;

  localparam logic [2*INST_WIDTH-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO; head word is combinational from storage, push lands next cycle.
// A push into a full FIFO is only accepted together with a pop; clr empties it in one cycle.
module inst_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    if (clr) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_dat;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Empty head reads as zero so a drained or flushed FIFO never shows stale words.
  assign empty    = (count_q == '0);
  assign head_dat = empty ? '0 : mem_q[rd_q];
  assign count    = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch sequencer: issues ROM reads from base for len words, buffers them for PE decode.
// start->rom_en 1 cycle, ->inst_valid 3 cycles; reads are credited against FIFO space so ready low stalls the ROM.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int INST_W       = INST_WIDTH * 2,
  parameter int ADDR_W       = 8,
  parameter int FIFO_DEPTH   = 2,
  parameter bit STOP_ON_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] prog_base,
  input  logic [ADDR_W:0]   prog_len,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] inst_out,
  output logic [OPC_W-1:0]  inst_opcode,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic              stop_q, stop_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_clr;
  logic              pop;
  logic              issue;
  logic              is_nop;
  logic [CNT_W:0]    occupancy;

  assign pop        = inst_valid && inst_ready;
  assign inst_valid = !fifo_empty;
  assign is_nop     = STOP_ON_ZERO && (rom_data == INST_W'(NOP_WORD));

  // Words buffered plus the read in flight, less the one leaving this cycle.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    remaining_d = remaining_q;
    inflight_d  = 1'b0;
    stop_d      = stop_q;
    issue       = 1'b0;
    fifo_push   = 1'b0;
    fifo_clr    = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          pc_d        = prog_base;
          remaining_d = prog_len;
          stop_d      = 1'b0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          fifo_clr = 1'b1;
          state_d  = ST_FLUSH;
        end else begin
          issue = (remaining_q != '0) && !stop_q && (occupancy < DEPTH_C);
          if (issue) begin
            pc_d        = pc_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            inflight_d  = 1'b1;
          end
          // Once an end-of-program word is seen, the read already behind it is dropped.
          if (inflight_q) begin
            if (is_nop) begin
              stop_d = 1'b1;
            end else if (!stop_q) begin
              fifo_push = 1'b1;
            end
          end
          if ((remaining_q == '0 || stop_q) && !inflight_q && fifo_count == '0) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        fifo_clr = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      stop_q      <= stop_d;
    end
  end

  assign rom_en      = issue;
  assign rom_addr    = pc_q;
  assign busy        = (state_q != ST_IDLE);
  assign inst_opcode = inst_out[INST_W-1 -: OPC_W];

  inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (fifo_clr),
    .push     (fifo_push),
    .push_dat (rom_data),
    .pop      (pop),
    .head_dat (inst_out),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: one DUT stops on zero words, a second one does not.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  prog_base;
  logic [8:0]  prog_len;
  logic        inst_ready;

  logic        a_rom_en, b_rom_en;
  logic [7:0]  a_rom_addr, b_rom_addr;
  logic [31:0] a_rom_data = '0, b_rom_data = '0;
  logic [31:0] a_inst_out, b_inst_out;
  logic [2:0]  a_inst_opcode, b_inst_opcode;
  logic        a_inst_valid, b_inst_valid;
  logic        a_busy, b_busy;
  logic        a_done, b_done;

  logic [31:0] rom [256];

  int tot = 0;
  int bad = 0;
  int cyc = 0;
  int t0  = 0;

  logic [7:0]  a_rd[$];
  int          a_rd_c[$];
  logic [31:0] a_pd[$];
  int          a_pc[$];
  int          a_dn[$];
  logic [7:0]  b_rd[$];
  logic [31:0] b_pd[$];
  int          b_dn[$];

  always #5 clk = ~clk;

  inst_fetch #(.STOP_ON_ZERO(1'b1)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .prog_base(prog_base), .prog_len(prog_len),
    .rom_en(a_rom_en), .rom_addr(a_rom_addr), .rom_data(a_rom_data),
    .inst_out(a_inst_out), .inst_opcode(a_inst_opcode), .inst_valid(a_inst_valid),
    .inst_ready(inst_ready), .busy(a_busy), .done(a_done)
  );

  inst_fetch #(.STOP_ON_ZERO(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .prog_base(prog_base), .prog_len(prog_len),
    .rom_en(b_rom_en), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .inst_out(b_inst_out), .inst_opcode(b_inst_opcode), .inst_valid(b_inst_valid),
    .inst_ready(inst_ready), .busy(b_busy), .done(b_done)
  );

  // Synchronous-read ROM models: data appears the cycle after the enable.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_rom_en) a_rom_data <= rom[a_rom_addr];
    if (b_rom_en) b_rom_data <= rom[b_rom_addr];
  end

  always @(negedge clk) begin
    if (a_rom_en) begin a_rd.push_back(a_rom_addr); a_rd_c.push_back(cyc - t0); end
    if (a_inst_valid && inst_ready) begin a_pd.push_back(a_inst_out); a_pc.push_back(cyc - t0); end
    if (a_done) a_dn.push_back(cyc - t0);
    if (b_rom_en) b_rd.push_back(b_rom_addr);
    if (b_inst_valid && inst_ready) b_pd.push_back(b_inst_out);
    if (b_done) b_dn.push_back(cyc - t0);
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; inst_ready = 1'b1;
    prog_base = '0; prog_len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic launch(input logic [7:0] base, input logic [8:0] len);
    @(posedge clk); #1;
    a_rd.delete(); a_rd_c.delete(); a_pd.delete(); a_pc.delete(); a_dn.delete();
    b_rd.delete(); b_pd.delete(); b_dn.delete();
    prog_base = base; prog_len = len; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_to(input int k);
    while (cyc - t0 < k) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; inst_ready = 1'b1;
    prog_base = '0; prog_len = '0;
    @(negedge clk);
    tot++;
    if ({a_rom_en, a_rom_addr, a_inst_out, a_inst_opcode, a_inst_valid, a_busy, a_done} !== '0) begin
      bad++; $display("FAIL reset_a: outputs got %h want 0",
        {a_rom_en, a_rom_addr, a_inst_out, a_inst_opcode, a_inst_valid, a_busy, a_done});
    end
    tot++;
    if ({b_rom_en, b_rom_addr, b_inst_out, b_inst_opcode, b_inst_valid, b_busy, b_done} !== '0) begin
      bad++; $display("FAIL reset_b: outputs got %h want 0",
        {b_rom_en, b_rom_addr, b_inst_out, b_inst_opcode, b_inst_valid, b_busy, b_done});
    end
    do_reset();
  endtask

  task automatic test_full_run();
    do_reset();
    launch(8'h00, 9'd32);
    wait_to(2); @(negedge clk);
    tot++; if (a_inst_valid !== 1'b0) begin bad++; $display("FAIL full_valid_c2: got %b want 0", a_inst_valid); end
    wait_to(3); @(negedge clk);
    tot++; if (a_inst_out !== 32'h80000040) begin bad++; $display("FAIL full_first_word: got %h want 80000040", a_inst_out); end
    tot++; if (a_inst_opcode !== 3'b100) begin bad++; $display("FAIL full_opcode: got %b want 100", a_inst_opcode); end
    wait_to(40); @(negedge clk);
    tot++; if (a_pd.size() !== 32) begin bad++; $display("FAIL full_words: got %0d want 32", a_pd.size()); end
    for (int i = 0; i < 32 && i < a_pd.size(); i++) begin
      tot++; if (a_pd[i] !== rom[i]) begin bad++; $display("FAIL full_word%0d: got %h want %h", i, a_pd[i], rom[i]); end
    end
    tot++; if (a_pd[$] !== 32'hD357535F) begin bad++; $display("FAIL full_last_word: got %h want d357535f", a_pd[$]); end
    tot++; if (a_pc[0] !== 3 || a_pc[$] !== 34) begin bad++; $display("FAIL full_pop_cycles: got %0d..%0d want 3..34", a_pc[0], a_pc[$]); end
    tot++; if (a_dn.size() !== 1 || a_dn[0] !== 35) begin bad++; $display("FAIL full_done: got n=%0d at %0d want 1 at 35", a_dn.size(), a_dn[0]); end
    tot++; if (a_rd.size() !== 32 || a_rd_c[0] !== 1 || a_rd_c[$] !== 32) begin
      bad++; $display("FAIL full_rom_en: got n=%0d %0d..%0d want 32 1..32", a_rd.size(), a_rd_c[0], a_rd_c[$]);
    end
    for (int i = 0; i < 32 && i < a_rd.size(); i++) begin
      tot++; if (a_rd[i] !== 8'(i)) begin bad++; $display("FAIL full_addr%0d: got %h want %h", i, a_rd[i], 8'(i)); end
    end
  endtask

  task automatic test_early_stop();
    do_reset();
    launch(8'h1E, 9'd10);
    wait_to(15); @(negedge clk);
    tot++; if (a_pd.size() !== 2) begin bad++; $display("FAIL stop_words: got %0d want 2", a_pd.size()); end
    tot++; if (a_pd[0] !== 32'hB357535E || a_pd[1] !== 32'hD357535F) begin
      bad++; $display("FAIL stop_data: got %h %h want b357535e d357535f", a_pd[0], a_pd[1]);
    end
    tot++; if (a_rd.size() !== 4 || a_rd[$] !== 8'h21) begin
      bad++; $display("FAIL stop_reads: got n=%0d last %h want 4 last 21", a_rd.size(), a_rd[$]);
    end
    tot++; if (a_dn.size() !== 1 || a_dn[0] !== 6) begin bad++; $display("FAIL stop_done: got n=%0d at %0d want 1 at 6", a_dn.size(), a_dn[0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    launch(8'hFF, 9'd2);
    wait_to(12); @(negedge clk);
    tot++; if (b_rd.size() !== 2 || b_rd[0] !== 8'hFF || b_rd[1] !== 8'h00) begin
      bad++; $display("FAIL wrap_addr: got n=%0d %h %h want ff 00", b_rd.size(), b_rd[0], b_rd[1]);
    end
    tot++; if (b_pd.size() !== 2 || b_pd[0] !== 32'h0 || b_pd[1] !== 32'h80000040) begin
      bad++; $display("FAIL wrap_data: got n=%0d %h %h want 00000000 80000040", b_pd.size(), b_pd[0], b_pd[1]);
    end
    tot++; if (b_dn.size() !== 1 || b_dn[0] !== 5) begin bad++; $display("FAIL wrap_done: got n=%0d at %0d want 1 at 5", b_dn.size(), b_dn[0]); end
  endtask

  task automatic test_backpressure();
    int early;
    do_reset();
    launch(8'h00, 9'd8);
    wait_to(3);
    inst_ready = 1'b0;
    for (int k = 3; k < 8; k++) begin
      wait_to(k); @(negedge clk);
      tot++; if (a_inst_valid !== 1'b1 || a_inst_out !== 32'h80000040) begin
        bad++; $display("FAIL bp_hold_c%0d: got v=%b %h want v=1 80000040", k, a_inst_valid, a_inst_out);
      end
      tot++; if (a_rom_en !== 1'b0) begin bad++; $display("FAIL bp_rom_en_c%0d: got %b want 0", k, a_rom_en); end
    end
    wait_to(8);
    inst_ready = 1'b1;
    wait_to(25); @(negedge clk);
    early = 0;
    foreach (a_rd_c[i]) if (a_rd_c[i] < 8) early++;
    tot++; if (early !== 2) begin bad++; $display("FAIL bp_credits: got %0d reads before release want 2", early); end
    tot++; if (a_pd.size() !== 8) begin bad++; $display("FAIL bp_words: got %0d want 8", a_pd.size()); end
    for (int i = 0; i < 8 && i < a_pd.size(); i++) begin
      tot++; if (a_pd[i] !== rom[i]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, a_pd[i], rom[i]); end
    end
    tot++; if (a_pc[0] !== 8 || a_pc[$] !== 15) begin bad++; $display("FAIL bp_pop_cycles: got %0d..%0d want 8..15", a_pc[0], a_pc[$]); end
    tot++; if (a_dn.size() !== 1 || a_dn[0] !== 16) begin bad++; $display("FAIL bp_done: got n=%0d at %0d want 1 at 16", a_dn.size(), a_dn[0]); end
  endtask

  task automatic test_abort();
    do_reset();
    launch(8'h00, 9'd32);
    wait_to(6);
    abort = 1'b1;
    wait_to(7);
    abort = 1'b0;
    @(negedge clk);
    tot++; if (a_busy !== 1'b1 || a_rom_en !== 1'b0 || a_inst_valid !== 1'b0) begin
      bad++; $display("FAIL abort_flush: got busy=%b en=%b v=%b want 1 0 0", a_busy, a_rom_en, a_inst_valid);
    end
    wait_to(8); @(negedge clk);
    tot++; if (a_busy !== 1'b0 || a_inst_valid !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%b v=%b want 0 0", a_busy, a_inst_valid);
    end
    wait_to(15); @(negedge clk);
    tot++; if (a_dn.size() !== 0 || a_rom_en !== 1'b0) begin
      bad++; $display("FAIL abort_no_done: got dones=%0d en=%b want 0 0", a_dn.size(), a_rom_en);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    launch(8'h00, 9'd32);
    wait_to(5); @(negedge clk);
    tot++; if (a_inst_valid !== 1'b1 || a_busy !== 1'b1) begin
      bad++; $display("FAIL midrst_pre: got v=%b busy=%b want 1 1", a_inst_valid, a_busy);
    end
    #1 rst = 1'b1;
    #1;
    tot++;
    if ({a_rom_en, a_rom_addr, a_inst_out, a_inst_valid, a_busy, a_done} !== '0) begin
      bad++; $display("FAIL midrst_outputs: got %h want 0", {a_rom_en, a_rom_addr, a_inst_out, a_inst_valid, a_busy, a_done});
    end
    do_reset();
  endtask

  task automatic test_start_busy();
    do_reset();
    launch(8'h00, 9'd8);
    wait_to(3);
    prog_base = 8'h40; prog_len = 9'd3; start = 1'b1;
    wait_to(4);
    start = 1'b0;
    wait_to(20); @(negedge clk);
    tot++; if (a_rd.size() !== 8 || a_rd[$] !== 8'h07) begin
      bad++; $display("FAIL busy_reads: got n=%0d last %h want 8 last 07", a_rd.size(), a_rd[$]);
    end
    tot++; if (a_pd.size() !== 8) begin bad++; $display("FAIL busy_words: got %0d want 8", a_pd.size()); end
    for (int i = 0; i < 8 && i < a_pd.size(); i++) begin
      tot++; if (a_pd[i] !== rom[i]) begin bad++; $display("FAIL busy_word%0d: got %h want %h", i, a_pd[i], rom[i]); end
    end
    tot++; if (a_dn.size() !== 1 || a_dn[0] !== 11 || a_busy !== 1'b0) begin
      bad++; $display("FAIL busy_done: got n=%0d at %0d busy=%b want 1 at 11 busy=0", a_dn.size(), a_dn[0], a_busy);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    launch(8'h10, 9'd0);
    @(negedge clk);
    tot++; if (a_done !== 1'b1 || a_rom_en !== 1'b0 || a_busy !== 1'b1) begin
      bad++; $display("FAIL zero_c1: got done=%b en=%b busy=%b want 1 0 1", a_done, a_rom_en, a_busy);
    end
    wait_to(6); @(negedge clk);
    tot++; if (a_rd.size() !== 0 || a_pd.size() !== 0) begin
      bad++; $display("FAIL zero_activity: got reads=%0d words=%0d want 0 0", a_rd.size(), a_pd.size());
    end
    tot++; if (a_dn.size() !== 1 || a_dn[0] !== 1) begin bad++; $display("FAIL zero_done: got n=%0d at %0d want 1 at 1", a_dn.size(), a_dn[0]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 | (32'(i) * 32'h0001_0101);
    rom[8'h00] = 32'h80000040;
    rom[8'h1E] = 32'hB357535E;
    rom[8'h1F] = 32'hD357535F;
    rom[8'h20] = 32'h00000000;
    rom[8'hFF] = 32'h00000000;

    test_reset();
    test_full_run();
    test_early_stop();
    test_wrap();
    test_backpressure();
    test_abort();
    test_reset_midrun();
    test_start_busy();
    test_zero_len();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
